// File: rtl/angle_reducer.sv
// Sine/cosine argument reducer: folds any 32-bit angle into the first quadrant,
// drives an external LUT, and returns the sign-corrected result.
module angle_reducer #(
  parameter logic [31:0] FULL_TURN = 32'd360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_in,
  input  logic [31:0] angle_in,
  output logic        lut_op,
  output logic [31:0] lut_angle,
  input  logic [31:0] lut_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);
  localparam logic [31:0] T4  = FULL_TURN >> 2;
  localparam logic [31:0] T2  = FULL_TURN >> 1;
  localparam logic [31:0] T34 = T2 + T4;

  typedef enum logic [2:0] {IDLE, REDUCE, MAP, LOOKUP, DONE} state_t;
  state_t state, state_nx;

  logic        op_q;
  logic        neg;
  logic [4:0]  cnt;
  logic [31:0] dvd, rem, rem_sh, rem_nx;
  logic [31:0] map_angle;
  logic [1:0]  quad;
  logic        map_neg;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = REDUCE;
      REDUCE:  if (cnt == 5'd31) state_nx = MAP;
      MAP:     state_nx = LOOKUP;
      LOOKUP:  state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Remainder stays below FULL_TURN < 2^31, so the shifted value fits in 32 bits.
  assign rem_sh = {rem[30:0], dvd[31]};
  assign rem_nx = (rem_sh >= FULL_TURN) ? rem_sh - FULL_TURN : rem_sh;

  always_comb begin
    map_angle = rem;
    quad      = 2'd0;
    if (rem <= T4) begin
      map_angle = rem;
      quad      = 2'd0;
    end else if (rem <= T2) begin
      map_angle = T2 - rem;
      quad      = 2'd1;
    end else if (rem <= T34) begin
      map_angle = rem - T2;
      quad      = 2'd2;
    end else begin
      map_angle = FULL_TURN - rem;
      quad      = 2'd3;
    end
  end

  // Sine is negative in Q2/Q3, cosine in Q1/Q2.
  assign map_neg = op_q ? quad[1] : (quad[1] ^ quad[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 1'b0;
      neg       <= 1'b0;
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      lut_op    <= 1'b0;
      lut_angle <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op_in;
          dvd  <= angle_in;
          rem  <= '0;
          cnt  <= '0;
        end
        REDUCE: begin
          rem <= rem_nx;
          dvd <= {dvd[30:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        MAP: begin
          lut_angle <= map_angle;
          lut_op    <= op_q;
          neg       <= map_neg;
        end
        LOOKUP: result <= neg ? 32'd0 - lut_value : lut_value;
        // out_valid is registered off DONE, so it rises one edge after entry.
        DONE: out_valid <= !(out_valid && out_ready);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_angle_reducer.sv
// Scoreboard bench for angle_reducer: random and directed angles against a
// modulo-arithmetic reference with a behavioural LUT.
module tb_angle_reducer;
  localparam int unsigned T = 360;

  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, op_in = 0;
  logic [31:0] angle_in = 0;
  logic        lut_op;
  logic [31:0] lut_angle, lut_value;
  logic        out_valid, out_ready = 0;
  logic [31:0] result;
  bit          lut_ovr = 0;

  angle_reducer #(.FULL_TURN(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_in(op_in), .angle_in(angle_in), .lut_op(lut_op), .lut_angle(lut_angle),
    .lut_value(lut_value), .out_valid(out_valid), .out_ready(out_ready),
    .result(result));

  always #5 clk = ~clk;

  // Behavioural LUT: sine -> angle, cosine -> T/4 - angle; override forces the most negative value.
  assign lut_value = lut_ovr ? 32'h8000_0000 :
                     (lut_op ? lut_angle : (T / 4) - lut_angle);

  typedef struct {
    logic [31:0] res;
    logic [31:0] la;
    logic        op;
    int          acc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, bp_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [31:0] a, input bit ovr);
    exp_t e;
    longint unsigned r = longint'(a) % T;
    longint unsigned la;
    bit              negative;
    logic [31:0]     v;
    if (r <= T / 4)          begin la = r;         negative = 0;  end
    else if (r <= T / 2)     begin la = T / 2 - r; negative = !op; end
    else if (r <= 3 * T / 4) begin la = r - T / 2; negative = 1;  end
    else                     begin la = T - r;     negative = op; end
    v     = ovr ? 32'h8000_0000 : (op ? 32'(la) : 32'(T / 4 - la));
    e.res = negative ? 32'(-longint'(v)) : v;
    e.la  = 32'(la);
    e.op  = op;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(input logic op, input logic [31:0] ang, input bit track);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin chk("issue_timeout", 0, 1); return; end
    op_in = op; angle_in = ang; in_valid = 1;
    if (track) begin
      e = model(op, ang, lut_ovr);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 0; angle_in = $urandom; op_in = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((q.size() != 0 || !in_ready) && t < 500) begin @(negedge clk); t++; end
    if (q.size() != 0) chk("idle_timeout", 32'(q.size()), 0);
  endtask

  // Monitor: owns out_ready, pops and checks whenever a result is presented.
  initial begin : monitor
    bit prev_valid = 0, hs_prev = 0, force_rdy = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_valid = 0; hs_prev = 0; continue; end
      if (hs_prev) begin
        chk("valid_drop", 32'(out_valid), 0);
        chk("ready_after_hs", 32'(in_ready), 1);
      end
      hs_prev = 0;
      if (out_valid && bp_hold > 0) begin
        out_ready = 0; bp_hold--; force_rdy = (bp_hold == 0);
      end else if (out_valid && force_rdy) begin
        out_ready = 1; force_rdy = 0;
      end else out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 32'(out_valid), 0);
        else begin
          cur = q[0];
          if (!prev_valid) chk("latency", 32'(cyc - cur.acc), 35);
          chk("result", result, cur.res);
          chk("lut_angle", lut_angle, cur.la);
          chk("lut_op", 32'(lut_op), 32'(cur.op));
          chk("busy_ready", 32'(in_ready), 0);
          if (out_ready) begin void'(q.pop_front()); hs_prev = 1; end
        end
      end
      prev_valid = out_valid;
    end
  end

  logic [31:0] dir_ang [12] = '{30, 210, 180, 90, 180, 270, 360, 0, 32'hFFFF_FFFF, 45, 135, 315};
  logic        dir_op  [12] = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_lut_angle", lut_angle, 0);
    chk("rst_lut_op", 32'(lut_op), 0);
    rst_n = 1;
    chk("rst_ready", 32'(in_ready), 1);

    for (int i = 0; i < 12; i++) begin
      if (i == 0) bp_hold = 10;
      issue(dir_op[i], dir_ang[i], 1);
      wait_idle();
    end

    // Most-negative LUT value must wrap to itself when negated.
    lut_ovr = 1;
    issue(1, 210, 1);
    wait_idle();
    lut_ovr = 0;

    // Abort mid-reduction: no output for this request, outputs return to reset values.
    issue(1, 100, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_result", result, 0);
    chk("abort_lut_angle", lut_angle, 0);
    chk("abort_lut_op", 32'(lut_op), 0);
    @(negedge clk);
    rst_n = 1;
    issue(0, 300, 1);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      logic [31:0] a;
      a = (i % 2 == 0) ? $urandom : $urandom_range(0, 2 * T);
      if (i == 7) bp_hold = 4;
      issue(1'($urandom), a, 1);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
